// File: rtl/procesador_result_pio_pkg.sv
// Shared constants for the result-capture PIO: register map, bit positions,
// counter width and ID word layout.
package procesador_result_pio_pkg;

    localparam int unsigned ADDR_STATUS = 12;
    localparam int unsigned ADDR_CTRL   = 13;
    localparam int unsigned ADDR_COUNT  = 14;
    localparam int unsigned ADDR_ID     = 15;

    localparam int unsigned STATUS_READY_BIT   = 0;
    localparam int unsigned STATUS_OVERRUN_BIT = 1;
    localparam int unsigned CTRL_IRQ_EN_BIT    = 0;
    localparam int unsigned CTRL_FREEZE_BIT    = 1;

    localparam int unsigned COUNT_W = 16;

    // ID word: {16'h0, N_CH[7:0], DATA_W[7:0]}
    localparam int unsigned ID_FIELD_W = 8;

    function automatic logic [31:0] make_id(input int unsigned n_ch, input int unsigned data_w);
        return {16'h0, ID_FIELD_W'(n_ch), ID_FIELD_W'(data_w)};
    endfunction

endpackage

// File: rtl/procesador_result_capture_bank.sv
// N_CH x DATA_W shadow registers loaded together on a common enable,
// with a combinational channel-select read port (out-of-range selects read 0).
module procesador_result_capture_bank
    import procesador_result_pio_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned N_CH   = 4,
    parameter int unsigned ADDR_W = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     load,
    input  logic [N_CH*DATA_W-1:0]   in_port,
    input  logic [ADDR_W-1:0]        rd_sel,
    output logic [DATA_W-1:0]        rd_data_c
);

    logic [DATA_W-1:0] snap_q [N_CH];
    logic [DATA_W-1:0] snap_d [N_CH];

    // Next-state: all channels load atomically from in_port
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            snap_d[i] = snap_q[i];
            if (load) begin
                snap_d[i] = in_port[i*DATA_W +: DATA_W];
            end
        end
    end

    // Shadow storage
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N_CH; i++) begin
                snap_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                snap_q[i] <= snap_d[i];
            end
        end
    end

    // Channel-select read port
    always_comb begin
        rd_data_c = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (rd_sel == ADDR_W'(i)) begin
                rd_data_c = snap_q[i];
            end
        end
    end

endmodule

// File: rtl/procesador_result_capture_pio.sv
// Avalon-MM slave publishing N_CH atomically captured result words with
// READY/OVERRUN status, a capture counter and a level interrupt.
// Optional feature macro: RESULT_PIO_IRQ_EN (IRQ_EN bit and irq output).
module procesador_result_capture_pio
    import procesador_result_pio_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned N_CH   = 4,
    parameter int unsigned ADDR_W = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [ADDR_W-1:0]        address,
    input  logic                     chipselect,
    input  logic                     write,
    input  logic [31:0]              writedata,
    output logic [31:0]              readdata,
    input  logic [N_CH*DATA_W-1:0]   in_port,
    input  logic                     in_valid,
    output logic                     irq
);

    logic               ready_q,    ready_d;
    logic               overrun_q,  overrun_d;
    logic [1:0]         ctrl_q,     ctrl_d;
    logic [COUNT_W-1:0] count_q,    count_d;
    logic [31:0]        readdata_q, readdata_d;
    logic               irq_q,      irq_d;

    logic               wr_c;
    logic               capture_c;
    logic               ready_clr_c;
    logic               overrun_clr_c;
    logic [DATA_W-1:0]  bank_rd_c;

    // Only the low CTRL/STATUS bits of writedata are architected
    logic unused_writedata;
    assign unused_writedata = &{1'b0, writedata[31:2]};

    procesador_result_capture_bank #(
        .DATA_W (DATA_W),
        .N_CH   (N_CH),
        .ADDR_W (ADDR_W)
    ) u_bank (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (capture_c),
        .in_port   (in_port),
        .rd_sel    (address),
        .rd_data_c (bank_rd_c)
    );

    // Next-state for status, control, counter, read mux and irq
    always_comb begin
        ready_d    = ready_q;
        overrun_d  = overrun_q;
        ctrl_d     = ctrl_q;
        count_d    = count_q;
        readdata_d = 32'(bank_rd_c);
        irq_d      = 1'b0;

        wr_c          = chipselect & write;
        capture_c     = in_valid & ~ctrl_q[CTRL_FREEZE_BIT];
        ready_clr_c   = wr_c && (address == ADDR_W'(ADDR_STATUS)) && writedata[STATUS_READY_BIT];
        overrun_clr_c = wr_c && (address == ADDR_W'(ADDR_STATUS)) && writedata[STATUS_OVERRUN_BIT];

        // Capture beats a concurrent READY clear
        if (capture_c) begin
            ready_d = 1'b1;
            count_d = count_q + COUNT_W'(1);
        end else if (ready_clr_c) begin
            ready_d = 1'b0;
        end

        // A new overrun beats a concurrent OVERRUN clear
        if (capture_c && ready_q && !ready_clr_c) begin
            overrun_d = 1'b1;
        end else if (overrun_clr_c) begin
            overrun_d = 1'b0;
        end

        if (wr_c && (address == ADDR_W'(ADDR_CTRL))) begin
`ifdef RESULT_PIO_IRQ_EN
            ctrl_d = writedata[1:0];
`else
            ctrl_d = {writedata[CTRL_FREEZE_BIT], 1'b0};
`endif
        end

`ifdef RESULT_PIO_IRQ_EN
        irq_d = ready_q & ctrl_q[CTRL_IRQ_EN_BIT];
`endif

        case (address)
            ADDR_W'(ADDR_STATUS): readdata_d = {30'h0, overrun_q, ready_q};
            ADDR_W'(ADDR_CTRL):   readdata_d = {30'h0, ctrl_q};
            ADDR_W'(ADDR_COUNT):  readdata_d = 32'(count_q);
            ADDR_W'(ADDR_ID):     readdata_d = make_id(N_CH, DATA_W);
            default:              readdata_d = 32'(bank_rd_c);
        endcase
    end

    // State registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ready_q    <= 1'b0;
            overrun_q  <= 1'b0;
            ctrl_q     <= 2'b00;
            count_q    <= '0;
            readdata_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            ready_q    <= ready_d;
            overrun_q  <= overrun_d;
            ctrl_q     <= ctrl_d;
            count_q    <= count_d;
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_procesador_result_capture_pio.sv
// Directed self-checking bench for procesador_result_capture_pio (N_CH=4, DATA_W=32).
module tb_procesador_result_capture_pio;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [3:0]   address;
    logic         chipselect;
    logic         write;
    logic [31:0]  writedata;
    logic [31:0]  readdata;
    logic [127:0] in_port;
    logic         in_valid;
    logic         irq;

    int checks = 0;
    int errors = 0;

    procesador_result_capture_pio #(
        .DATA_W (32),
        .N_CH   (4),
        .ADDR_W (4)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write      (write),
        .writedata  (writedata),
        .readdata   (readdata),
        .in_port    (in_port),
        .in_valid   (in_valid),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic rd(input logic [3:0] a, input logic [31:0] exp, input string tag);
        @(negedge clk);
        address    = a;
        chipselect = 1'b1;
        write      = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        chk(tag, readdata, exp);
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write      = 1'b1;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write      = 1'b0;
    endtask

    task automatic cap();
        @(negedge clk);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic cap_wr(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write      = 1'b1;
        in_valid   = 1'b1;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write      = 1'b0;
        in_valid   = 1'b0;
    endtask

    initial begin
        logic [31:0] exp_ctrl_irq;
        logic        exp_irq;
`ifdef RESULT_PIO_IRQ_EN
        exp_ctrl_irq = 32'h1;
        exp_irq      = 1'b1;
`else
        exp_ctrl_irq = 32'h0;
        exp_irq      = 1'b0;
`endif
        reset_n    = 1'b0;
        address    = '0;
        chipselect = 1'b0;
        write      = 1'b0;
        writedata  = '0;
        in_port    = '0;
        in_valid   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // Reset state and register map
        chk("irq_reset", 32'(irq), 32'h0);
        for (int a = 0; a < 16; a++) begin
            rd(4'(a), (a == 15) ? 32'h0000_0420 : 32'h0, $sformatf("reset_addr%0d", a));
        end

        // Single capture
        in_port = {32'hDDDD0003, 32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000};
        cap();
        in_port = {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
        rd(4'd0, 32'hAAAA0000, "snap0");
        rd(4'd1, 32'hBBBB0001, "snap1");
        rd(4'd2, 32'hCCCC0002, "snap2");
        rd(4'd3, 32'hDDDD0003, "snap3");
        rd(4'd12, 32'h1, "status_after_cap");
        rd(4'd14, 32'h1, "count_after_cap");
        rd(4'd4, 32'h0, "unmapped4");

        // Writes to read-only addresses are ignored
        wr(4'd0, 32'h12345678);
        wr(4'd14, 32'h0000ABCD);
        rd(4'd0, 32'hAAAA0000, "snap0_ro");
        rd(4'd14, 32'h1, "count_ro");

        // Overrun, W1C, capture vs clear
        in_port = {32'hDDDD0003, 32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000};
        cap();
        rd(4'd12, 32'h3, "status_overrun");
        wr(4'd12, 32'h3);
        rd(4'd12, 32'h0, "status_w1c");
        cap();
        cap_wr(4'd12, 32'h1);
        rd(4'd12, 32'h1, "status_cap_beats_clr");
        rd(4'd14, 32'h4, "count_4");
        cap();
        rd(4'd12, 32'h3, "status_overrun2");
        cap_wr(4'd12, 32'h2);
        rd(4'd12, 32'h3, "overrun_set_wins");
        wr(4'd12, 32'h3);
        rd(4'd12, 32'h0, "status_clear2");

        // Interrupt
        wr(4'd13, 32'h1);
        rd(4'd13, exp_ctrl_irq, "ctrl_irq_en");
        cap();
        @(posedge clk);
        #1;
        chk("irq_rise", 32'(irq), 32'(exp_irq));
        wr(4'd12, 32'h1);
        @(posedge clk);
        #1;
        chk("irq_fall", 32'(irq), 32'h0);
        wr(4'd13, 32'h0);
        rd(4'd14, 32'h7, "count_7");

        // Freeze holds everything
        wr(4'd13, 32'h2);
        rd(4'd13, 32'h2, "ctrl_freeze");
        in_port = {32'h99999999, 32'h88888888, 32'h77777777, 32'h66666666};
        repeat (5) cap();
        rd(4'd14, 32'h7, "count_frozen");
        rd(4'd0, 32'hAAAA0000, "snap0_frozen");
        rd(4'd12, 32'h0, "status_frozen");
        wr(4'd13, 32'h0);

        // Asynchronous reset mid-operation
        cap();
        wr(4'd13, 32'h3);
        rd(4'd13, exp_ctrl_irq | 32'h2, "ctrl_before_reset");
        @(posedge clk);
        #1;
        chk("irq_before_reset", 32'(irq), 32'(exp_irq));
        #2;
        reset_n = 1'b0;
        #1;
        chk("readdata_async_reset", readdata, 32'h0);
        chk("irq_async_reset", 32'(irq), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int a = 0; a < 16; a++) begin
            rd(4'(a), (a == 15) ? 32'h0000_0420 : 32'h0, $sformatf("post_reset_addr%0d", a));
        end

        // Counter wrap
        @(negedge clk);
        in_valid = 1'b1;
        repeat (65535) @(posedge clk);
        #1;
        in_valid = 1'b0;
        rd(4'd14, 32'h0000FFFF, "count_ffff");
        cap();
        rd(4'd14, 32'h0, "count_wrap");
        rd(4'd12, 32'h3, "status_after_wrap");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
